// File: rtl/imem_boot_loader.sv
// Purpose: loads a framed byte stream (length, big-endian words, XOR checksum) into instruction memory.
// Latency: a word's write strobe is registered one cycle after its 4th byte; full-rate bytes never stall.
// Backpressure: byte_ready is high while loading, low in DONE/ERR until reload or reset.
module imem_boot_loader #(
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset_n,
    output logic              done,
    output logic              error
);

    localparam int IDX_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_WORD,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state;
    logic [7:0]       len_hi;
    logic [7:0]       csum;
    logic [IDX_W-1:0] word_idx;
    logic [IDX_W-1:0] last_idx;
    logic [1:0]       byte_cnt;
    logic [23:0]      shift;

    logic        accept;
    logic [15:0] len_n;
    logic        oversize;

    assign accept   = byte_valid && byte_ready;
    assign len_n    = {len_hi, byte_data};
    assign oversize = ({16'd0, len_n} > 32'(DEPTH));

    // Status outputs are pure decodes of the state register.
    assign byte_ready  = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                         (state == S_WORD)   || (state == S_CSUM);
    assign done        = (state == S_DONE);
    assign error       = (state == S_ERR);
    assign cpu_reset_n = (state == S_DONE);

    // Frame parser: length capture, word packing with write strobe, checksum verify, reload.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state      <= S_LEN_HI;
            len_hi     <= '0;
            csum       <= '0;
            word_idx   <= '0;
            last_idx   <= '0;
            byte_cnt   <= '0;
            shift      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_LEN_HI: begin
                    if (accept) begin
                        len_hi <= byte_data;
                        csum   <= csum ^ byte_data;
                        state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        csum <= csum ^ byte_data;
                        if (oversize) begin
                            state <= S_ERR;
                        end else if (len_n == 16'd0) begin
                            state <= S_CSUM;
                        end else begin
                            last_idx <= IDX_W'(len_n - 16'd1);
                            state    <= S_WORD;
                        end
                    end
                end
                S_WORD: begin
                    if (accept) begin
                        csum <= csum ^ byte_data;
                        if (byte_cnt == 2'd3) begin
                            // Fourth byte completes the word: strobe it out this edge.
                            imem_we    <= 1'b1;
                            imem_wdata <= {shift, byte_data};
                            imem_addr  <= BASE_ADDR + (ADDR_W'(word_idx) << 2);
                            word_idx   <= word_idx + IDX_W'(1);
                            byte_cnt   <= 2'd0;
                            if (word_idx == last_idx) begin
                                state <= S_CSUM;
                            end
                        end else begin
                            shift    <= {shift[15:0], byte_data};
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        state <= (byte_data == csum) ? S_DONE : S_ERR;
                    end
                end
                S_DONE, S_ERR: begin
                    if (reload) begin
                        state    <= S_LEN_HI;
                        csum     <= '0;
                        word_idx <= '0;
                        byte_cnt <= '0;
                        shift    <= '0;
                    end
                end
                default: state <= S_LEN_HI;
            endcase
        end
    end

endmodule
